// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter for the single-port data memory.
// Optional DMEM_ARB_LOCK_EN adds m0_lock/m1_lock to suppress hold preemption.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_LOCK_EN
  ,
  input  logic              m0_lock,
  input  logic              m1_lock
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam logic [4:0] LP_MAX = 5'(MAX_HOLD);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_hold_cnt;
  logic [3:0]  w_hold_nxt;
  logic [3:0]  w_hold_inc;
  logic        r_last_grant;
  logic        w_last_nxt;
  logic        w_limit;
  logic        w_lock0;
  logic        w_lock1;
  logic        w_rd0;
  logic        w_rd1;

`ifdef DMEM_ARB_LOCK_EN
  assign w_lock0 = m0_lock;
  assign w_lock1 = m1_lock;
`else
  assign w_lock0 = 1'b0;
  assign w_lock1 = 1'b0;
`endif

  // >= rather than == so a counter that ran past the limit
  // while the other side was quiet still yields on its next request
  assign w_limit = (5'(r_hold_cnt) + 5'd1) >= LP_MAX;
  assign w_hold_inc = (r_hold_cnt == 4'hF) ?
                      r_hold_cnt : r_hold_cnt + 4'd1;

  always_comb begin
    w_next         = r_state;
    w_hold_nxt     = r_hold_cnt;
    w_last_nxt     = r_last_grant;
    m0_ready       = 1'b0;
    m1_ready       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    unique case (r_state)
      IDLE: begin
        if (m0_req && (!m1_req || r_last_grant))
          w_next = SERVE0;
        else if (m1_req)
          w_next = SERVE1;
      end
      SERVE0: begin
        if (m0_req) begin
          m0_ready       = 1'b1;
          mem_read       = !m0_we;
          mem_write      = m0_we;
          mem_address    = m0_addr;
          mem_write_data = m0_wdata;
          w_hold_nxt     = w_hold_inc;
          if (w_limit && m1_req && !w_lock0) begin
            w_next     = SERVE1;
            w_hold_nxt = 4'd0;
            w_last_nxt = 1'b0;
          end
        end else begin
          w_next     = m1_req ? SERVE1 : IDLE;
          w_hold_nxt = 4'd0;
          w_last_nxt = 1'b0;
        end
      end
      SERVE1: begin
        if (m1_req) begin
          m1_ready       = 1'b1;
          mem_read       = !m1_we;
          mem_write      = m1_we;
          mem_address    = m1_addr;
          mem_write_data = m1_wdata;
          w_hold_nxt     = w_hold_inc;
          if (w_limit && m0_req && !w_lock1) begin
            w_next     = SERVE0;
            w_hold_nxt = 4'd0;
            w_last_nxt = 1'b1;
          end
        end else begin
          w_next     = m0_req ? SERVE0 : IDLE;
          w_hold_nxt = 4'd0;
          w_last_nxt = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_rd0 = m0_ready && !m0_we;
  assign w_rd1 = m1_ready && !m1_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold_cnt   <= 4'd0;
      r_last_grant <= 1'b1;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      r_state      <= w_next;
      r_hold_cnt   <= w_hold_nxt;
      r_last_grant <= w_last_nxt;
      m0_rvalid    <= w_rd0;
      m1_rvalid    <= w_rd1;
      if (w_rd0)
        m0_rdata <= mem_read_data;
      if (w_rd1)
        m1_rdata <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: memory model, read-data scoreboard,
// and per-scenario timing checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
`ifdef DMEM_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem  [1024];
  logic [31:0] refm [1024];
  logic        mem_init;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        pw0, pw1;
  logic [31:0] pa0, pd0, pa1, pd1;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_LOCK_EN
    , .m0_lock(m0_lock), .m1_lock(m1_lock)
`endif
  );

  assign mem_read_data = mem[mem_address[11:2]];

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 ^ 32'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]  <= init_val(i);
        refm[i] = init_val(i);
      end
    end else begin
      if (mem_write)
        mem[mem_address[11:2]] <= mem_write_data;
      if (!reset) begin
        if (pw0) refm[pa0[11:2]] = pd0;
        if (pw1) refm[pa1[11:2]] = pd1;
      end
    end
  end

  logic [31:0] e0, e1;
  always @(negedge clk) begin
    pw0 = m0_ready && m0_we; pa0 = m0_addr; pd0 = m0_wdata;
    pw1 = m1_ready && m1_we; pa1 = m1_addr; pd1 = m1_wdata;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (m0_ready && !m0_we) q0.push_back(refm[m0_addr[11:2]]);
      if (m1_ready && !m1_we) q1.push_back(refm[m1_addr[11:2]]);
      if (m0_rvalid) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL sb_m0_unexpected got=%h want=none", m0_rdata);
        end else begin
          e0 = q0.pop_front();
          if (m0_rdata !== e0) begin
            bad++;
            $display("FAIL sb_m0_rdata got=%h want=%h", m0_rdata, e0);
          end
        end
      end
      if (m1_rvalid) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL sb_m1_unexpected got=%h want=none", m1_rdata);
        end else begin
          e1 = q1.pop_front();
          if (m1_rdata !== e1) begin
            bad++;
            $display("FAIL sb_m1_rdata got=%h want=%h", m1_rdata, e1);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m0_op(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input bit keep,
                       output int lat);
    m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m0_ready) begin
        lat = c;
        break;
      end
      tick();
    end
    tick();
    if (!keep) begin
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_init = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
`ifdef DMEM_ARB_LOCK_EN
    m0_lock = 0; m1_lock = 0;
`endif
    tick(); tick();
    mem_init = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_ready, m1_ready, m0_rvalid, m1_rvalid,
         mem_read, mem_write} !== 6'b0) begin
      bad++;
      $display("FAIL rst_ctrl got=%b want=000000",
               {m0_ready, m1_ready, m0_rvalid, m1_rvalid,
                mem_read, mem_write});
    end
    total++;
    if ({m0_rdata, m1_rdata, mem_address, mem_write_data} !== 128'b0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h/%h/%h want=0",
               m0_rdata, m1_rdata, mem_address, mem_write_data);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_read, mem_write, m0_ready, m1_ready} !== 4'b0) begin
      bad++;
      $display("FAIL idle_quiet got=%b want=0000",
               {mem_read, mem_write, m0_ready, m1_ready});
    end
    tick();
  endtask

  task automatic test_write_read;
    int lat;
    m0_op(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, lat);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL wr_first_latency got=%0d want=1", lat);
    end
    m0_we = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_ready, mem_read, mem_write} !== 3'b110 ||
        mem_address !== 32'h10) begin
      bad++;
      $display("FAIL rd_b2b got=%b addr=%h want=110 addr=10",
               {m0_ready, mem_read, mem_write}, mem_address);
    end
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rd_data got=%b/%h want=1/deadbeef",
               m0_rvalid, m0_rdata);
    end
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rvalid_pulse got=%b want=0", m0_rvalid);
    end
    tick();
  endtask

  task automatic test_tie;
    int t0 = -1;
    int t1 = -1;
    int both = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    m1_req = 1; m1_we = 0; m1_addr = 32'h44;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m0_ready && m1_ready) both++;
      if (m0_ready && t0 < 0) t0 = c;
      if (m1_ready && t1 < 0) t1 = c;
      tick();
      if (c == t0) m0_req = 0;
      if (c == t1) m1_req = 0;
    end
    total++;
    if (t0 !== 1) begin
      bad++;
      $display("FAIL tie_m0_first got=%0d want=1", t0);
    end
    total++;
    if (t1 <= t0 || t1 > t0 + 2) begin
      bad++;
      $display("FAIL tie_m1_next got=%0d want=%0d..%0d", t1, t0 + 1, t0 + 2);
    end
    total++;
    if (both !== 0) begin
      bad++;
      $display("FAIL tie_excl got=%0d want=0", both);
    end
  endtask

  task automatic test_hold;
    int n0 = 0;
    int at = -1;
    int gap = 0;
    int both = 0;
    bit prev0 = 0;
    bit r0, r1, m1_done = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      r0 = m0_ready; r1 = m1_ready;
      if (r0 && r1) both++;
      if (r1) begin
        at = n0;
        gap = prev0 ? 0 : 1;
      end
      if (r0) n0++;
      prev0 = r0;
      tick();
      if (r0) begin
        if (n0 == 10) m0_req = 0;
        else m0_addr = 32'h100 + 32'(4 * n0);
      end
      if (r1) begin
        m1_req = 0;
        m1_done = 1;
      end
      if (n0 == 10 && m1_done) break;
    end
    total++;
    if (at !== 4) begin
      bad++;
      $display("FAIL hold_switch_at got=%0d want=4", at);
    end
    total++;
    if (gap !== 0) begin
      bad++;
      $display("FAIL hold_no_gap got=%0d want=0", gap);
    end
    total++;
    if (n0 !== 10 || both !== 0) begin
      bad++;
      $display("FAIL hold_m0_done got=%0d/%0d want=10/0", n0, both);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen = 0;
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m1_ready) begin
        seen = 1;
        break;
      end
      tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL midrst_ready got=0 want=1");
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({m0_ready, m1_ready, m0_rvalid, m1_rvalid, mem_read, mem_write,
         mem_address, mem_write_data, m0_rdata, m1_rdata} !== '0) begin
      bad++;
      $display("FAIL midrst_outs got=%b%b%b%b%b%b %h %h %h %h want=0",
               m0_ready, m1_ready, m0_rvalid, m1_rvalid, mem_read,
               mem_write, mem_address, mem_write_data, m0_rdata, m1_rdata);
    end
    tick();
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    reset = 1'b0;
    total++;
    if (mem[8] !== init_val(8)) begin
      bad++;
      $display("FAIL midrst_mem got=%h want=%h", mem[8], init_val(8));
    end
    m0_op(1'b0, 32'h20, 32'h0, 1'b0, lat);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL midrst_idle got=%0d want=1", lat);
    end
    tick();
  endtask

  task automatic test_misaligned;
    int lat;
    m0_op(1'b1, 32'h1000, 32'h1234_5678, 1'b1, lat);
    m0_we = 0; m0_addr = 32'h1003;
    @(negedge clk);
    total++;
    if (m0_ready !== 1'b1 || mem_address !== 32'h1003) begin
      bad++;
      $display("FAIL mis_addr got=%b/%h want=1/1003", m0_ready, mem_address);
    end
    tick();
    m0_req = 0;
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL mis_data got=%b/%h want=1/12345678",
               m0_rvalid, m0_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat;
    m0_op(1'b0, 32'h30, 32'h0, 1'b1, lat);
    m0_we = 1; m0_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    total++;
    if (m0_ready !== 1'b1 || mem_write !== 1'b1) begin
      bad++;
      $display("FAIL b2b_wr got=%b/%b want=1/1", m0_ready, mem_write);
    end
    total++;
    if (m0_rdata !== init_val(12)) begin
      bad++;
      $display("FAIL b2b_old got=%h want=%h", m0_rdata, init_val(12));
    end
    tick();
    m0_we = 0;
    @(negedge clk);
    total++;
    if (m0_ready !== 1'b1 || mem_read !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rd got=%b/%b want=1/1", m0_ready, mem_read);
    end
    tick();
    m0_req = 0;
    @(negedge clk);
    total++;
    if (m0_rdata !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL b2b_new got=%h want=0badf00d", m0_rdata);
    end
    tick();
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock;
    int n0 = 0;
    int at = -1;
    bit r0, r1, m1_done = 0;
    m0_lock = 1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h300; m0_wdata = 32'h5000;
    m1_req = 1; m1_we = 0; m1_addr = 32'h304;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      r0 = m0_ready; r1 = m1_ready;
      if (r1) at = n0;
      if (r0) n0++;
      tick();
      if (r0) begin
        if (n0 == 8) begin
          m0_req = 0; m0_we = 0; m0_lock = 0;
        end else begin
          m0_addr = 32'h300 + 32'(4 * n0);
          m0_wdata = 32'h5000 + 32'(n0);
        end
      end
      if (r1) begin
        m1_req = 0;
        m1_done = 1;
      end
      if (n0 == 8 && m1_done) break;
    end
    total++;
    if (at !== 8) begin
      bad++;
      $display("FAIL lock_hold got=%0d want=8", at);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_hold();
    test_reset_mid();
    test_misaligned();
    test_back_to_back();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    tick(); tick();
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
